// File: rtl/oup_ulpi_pkg.sv
// Shared types and constants for the ULPI PHY-side responder model:
// FSM state encoding, TX CMD prefixes, register map, reset defaults and
// the RX CMD byte packing helper.
package oup_ulpi_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD_ACK,
    WR_DATA,
    WR_STP,
    RD_TURN,
    RD_DATA,
    TURN_BACK,
    RX_TURN,
    RX_DATA
  } state_t;

  // TX CMD prefix in ulpi_data[7:6]; [5:0] carries the immediate address.
  localparam logic [1:0] TXCMD_REGWR = 2'b10;
  localparam logic [1:0] TXCMD_REGRD = 2'b11;

  // Read-only identification bytes.
  localparam logic [5:0] ADDR_VID_LO = 6'h00;
  localparam logic [5:0] ADDR_VID_HI = 6'h01;
  localparam logic [5:0] ADDR_PID_LO = 6'h02;
  localparam logic [5:0] ADDR_PID_HI = 6'h03;

  // Writable registers: base address writes, base+1 sets, base+2 clears.
  localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
  localparam logic [5:0] ADDR_IFC_CTRL  = 6'h07;
  localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;
  localparam logic [5:0] ADDR_SCRATCH   = 6'h16;
  localparam logic [5:0] SET_OFFSET     = 6'd1;
  localparam logic [5:0] CLR_OFFSET     = 6'd2;

  localparam int NUM_REGS       = 4;
  localparam int FUNC_IDX       = 0;
  localparam int FUNC_RESET_BIT = 5;

  localparam logic [5:0] REG_BASE [NUM_REGS] = '{
    ADDR_FUNC_CTRL, ADDR_IFC_CTRL, ADDR_OTG_CTRL, ADDR_SCRATCH
  };
  localparam logic [7:0] REG_DEFAULT [NUM_REGS] = '{
    8'h41, 8'h00, 8'h06, 8'h00
  };

  // RX CMD byte: {0, ID, 00, VBUS[1:0], LineState[1:0]}.
  function automatic logic [7:0] rx_cmd_pack(input logic id, input logic [1:0] vbus,
                                             input logic [1:0] linestate);
    return {1'b0, id, 2'b00, vbus, linestate};
  endfunction

endpackage

// File: rtl/oup_ulpi_phy_model_if.sv
// ULPI bus bundle between a link (master) and the PHY model (slave).
interface oup_ulpi_phy_model_if;

  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe_o;
  logic       ulpi_dir_o;
  logic       ulpi_nxt_o;
  logic       ulpi_stp_i;

  modport master (
    output ulpi_data_i,
    output ulpi_stp_i,
    input  ulpi_data_o,
    input  ulpi_data_oe_o,
    input  ulpi_dir_o,
    input  ulpi_nxt_o
  );

  modport slave (
    input  ulpi_data_i,
    input  ulpi_stp_i,
    output ulpi_data_o,
    output ulpi_data_oe_o,
    output ulpi_dir_o,
    output ulpi_nxt_o
  );

endinterface

// File: rtl/oup_ulpi_phy_regfile.sv
// ULPI immediate-address register file: ID bytes, four writable registers
// with write/set/clr aliases, read mux, and a soft reset that restores all
// defaults when a Function Control write would leave the Reset bit set.
module oup_ulpi_phy_regfile
  import oup_ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] func_ctrl,
  output logic       soft_rst
);

  logic [7:0] reg_val    [NUM_REGS];
  logic       reg_hit    [NUM_REGS];
  logic [7:0] reg_merged [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [7:0] value_reg;
    logic       hit;
    logic [7:0] merged;

    // Alias decode: value this register would take if the write commits.
    always_comb begin
      hit    = 1'b0;
      merged = value_reg;
      if (wr_addr == REG_BASE[gi]) begin
        hit    = 1'b1;
        merged = wr_data;
      end else if (wr_addr == REG_BASE[gi] + SET_OFFSET) begin
        hit    = 1'b1;
        merged = value_reg | wr_data;
      end else if (wr_addr == REG_BASE[gi] + CLR_OFFSET) begin
        hit    = 1'b1;
        merged = value_reg & ~wr_data;
      end
    end

    // Register storage; a soft reset takes precedence over the write itself.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        value_reg <= REG_DEFAULT[gi];
      end else if (soft_rst) begin
        value_reg <= REG_DEFAULT[gi];
      end else if (wr_en && hit) begin
        value_reg <= merged;
      end
    end

    assign reg_val[gi]    = value_reg;
    assign reg_hit[gi]    = hit;
    assign reg_merged[gi] = merged;
  end

  // The Reset bit is self-clearing: it is never stored, it triggers defaults.
  assign soft_rst  = wr_en && reg_hit[FUNC_IDX] && reg_merged[FUNC_IDX][FUNC_RESET_BIT];
  assign func_ctrl = reg_val[FUNC_IDX];

  // Read mux: every alias returns the register; anything unmapped
  // (including the extended-address escape 6'h2F) reads as zero.
  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_VID_LO: rd_data = VENDOR_ID[7:0];
      ADDR_VID_HI: rd_data = VENDOR_ID[15:8];
      ADDR_PID_LO: rd_data = PRODUCT_ID[7:0];
      ADDR_PID_HI: rd_data = PRODUCT_ID[15:8];
      default: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rd_addr == REG_BASE[i] || rd_addr == REG_BASE[i] + SET_OFFSET ||
              rd_addr == REG_BASE[i] + CLR_OFFSET) begin
            rd_data = reg_val[i];
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/oup_ulpi_phy_model.sv
// PHY-side ULPI responder: decodes register TX CMDs from the link, answers
// reads with bus turnarounds, and sends RX CMD bytes on line state / VBUS /
// ID changes. Optional feature macro OUP_ULPI_PHY_NXT_THROTTLE_EN delays
// nxt by NXT_DELAY cycles on every accepted TX CMD.
module oup_ulpi_phy_model
  import oup_ulpi_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009,
  parameter int unsigned NXT_DELAY  = 2
) (
  input  logic                       ulpi_clk_i,
  input  logic                       rst_n_i,
  oup_ulpi_phy_model_if.slave        ulpi,
  input  logic [1:0]                 linestate_i,
  input  logic [1:0]                 vbus_i,
  input  logic                       id_i,
  output logic [7:0]                 func_ctrl_o,
  output logic                       phy_reset_o
);

  state_t     state_reg, state_next;
  logic       dir_reg, dir_next;
  logic       oe_reg, oe_next;
  logic       nxt_reg, nxt_next;
  logic [7:0] data_o_reg, data_o_next;
  logic [5:0] addr_reg, addr_next;
  logic       is_read_reg, is_read_next;
  logic [7:0] wr_data_reg, wr_data_next;
  logic       pending_reg, pending_next;
  logic [4:0] last_reg, last_next;
  logic       phy_reset_reg;

  logic       wr_en;
  logic       soft_rst;
  logic [7:0] rd_data;
  logic [4:0] cur_ev;
  logic       is_txcmd;

  assign cur_ev   = {id_i, vbus_i, linestate_i};
  assign is_txcmd = (ulpi.ulpi_data_i[7:6] == TXCMD_REGWR) ||
                    (ulpi.ulpi_data_i[7:6] == TXCMD_REGRD);

`ifdef OUP_ULPI_PHY_NXT_THROTTLE_EN
  logic [7:0] wait_cnt_reg, wait_cnt_next;

  // Throttle countdown while the link holds the TX CMD in CMD_ACK.
  always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_reg <= 8'd0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`else
  logic [31:0] unused_nxt_delay;
  assign unused_nxt_delay = NXT_DELAY;
`endif

  oup_ulpi_phy_regfile #(
    .VENDOR_ID  (VENDOR_ID),
    .PRODUCT_ID (PRODUCT_ID)
  ) u_regfile (
    .clk       (ulpi_clk_i),
    .rst_n     (rst_n_i),
    .wr_en     (wr_en),
    .wr_addr   (addr_reg),
    .wr_data   (wr_data_reg),
    .rd_addr   (addr_reg),
    .rd_data   (rd_data),
    .func_ctrl (func_ctrl_o),
    .soft_rst  (soft_rst)
  );

  // Next-state and next-output decode; every bus output is registered.
  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    oe_next      = oe_reg;
    nxt_next     = 1'b0;
    data_o_next  = data_o_reg;
    addr_next    = addr_reg;
    is_read_next = is_read_reg;
    wr_data_next = wr_data_reg;
    pending_next = pending_reg | (cur_ev != last_reg);
    last_next    = last_reg;
    wr_en        = 1'b0;
`ifdef OUP_ULPI_PHY_NXT_THROTTLE_EN
    wait_cnt_next = wait_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        dir_next = 1'b0;
        oe_next  = 1'b0;
        // A TX CMD beats a pending RX CMD; pending is simply kept.
        if (!dir_reg && is_txcmd) begin
          state_next   = CMD_ACK;
          addr_next    = ulpi.ulpi_data_i[5:0];
          is_read_next = (ulpi.ulpi_data_i[7:6] == TXCMD_REGRD);
`ifdef OUP_ULPI_PHY_NXT_THROTTLE_EN
          wait_cnt_next = 8'(NXT_DELAY);
          nxt_next      = (NXT_DELAY == 0);
`else
          nxt_next      = 1'b1;
`endif
        end else if (!dir_reg && pending_reg && ulpi.ulpi_data_i == 8'h00 &&
                     !ulpi.ulpi_stp_i) begin
          state_next = RX_TURN;
          dir_next   = 1'b1;
        end
      end
      CMD_ACK: begin
        if (ulpi.ulpi_stp_i) begin
          state_next = IDLE;
        end
`ifdef OUP_ULPI_PHY_NXT_THROTTLE_EN
        else if (wait_cnt_reg != 8'd0) begin
          wait_cnt_next = wait_cnt_reg - 8'd1;
          nxt_next      = (wait_cnt_reg == 8'd1);
        end
`endif
        else if (is_read_reg) begin
          state_next = RD_TURN;
          dir_next   = 1'b1;
          oe_next    = 1'b0;
        end else begin
          state_next = WR_DATA;
          nxt_next   = 1'b1;
        end
      end
      WR_DATA: begin
        wr_data_next = ulpi.ulpi_data_i;
        state_next   = WR_STP;
      end
      WR_STP: begin
        // One cycle for stp; without it the captured byte is dropped.
        wr_en      = ulpi.ulpi_stp_i;
        state_next = IDLE;
      end
      RD_TURN: begin
        state_next  = RD_DATA;
        oe_next     = 1'b1;
        data_o_next = rd_data;
      end
      RD_DATA, RX_DATA: begin
        state_next  = TURN_BACK;
        dir_next    = 1'b0;
        oe_next     = 1'b0;
        data_o_next = 8'h00;
      end
      TURN_BACK: begin
        state_next = IDLE;
      end
      RX_TURN: begin
        state_next   = RX_DATA;
        oe_next      = 1'b1;
        data_o_next  = rx_cmd_pack(id_i, vbus_i, linestate_i);
        last_next    = cur_ev;
        pending_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
        dir_next   = 1'b0;
        oe_next    = 1'b0;
      end
    endcase

    // After a soft PHY reset the link must be told the current line state.
    if (soft_rst) begin
      pending_next = 1'b1;
    end
  end

  // State and output registers; reset drops dir/oe without waiting for a clock.
  always_ff @(posedge ulpi_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      dir_reg       <= 1'b0;
      oe_reg        <= 1'b0;
      nxt_reg       <= 1'b0;
      data_o_reg    <= 8'h00;
      addr_reg      <= 6'h00;
      is_read_reg   <= 1'b0;
      wr_data_reg   <= 8'h00;
      pending_reg   <= 1'b1;
      last_reg      <= 5'd0;
      phy_reset_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      oe_reg        <= oe_next;
      nxt_reg       <= nxt_next;
      data_o_reg    <= data_o_next;
      addr_reg      <= addr_next;
      is_read_reg   <= is_read_next;
      wr_data_reg   <= wr_data_next;
      pending_reg   <= pending_next;
      last_reg      <= last_next;
      phy_reset_reg <= soft_rst;
    end
  end

  assign ulpi.ulpi_data_o    = data_o_reg;
  assign ulpi.ulpi_data_oe_o = oe_reg;
  assign ulpi.ulpi_dir_o     = dir_reg;
  assign ulpi.ulpi_nxt_o     = nxt_reg;
  assign phy_reset_o         = phy_reset_reg;

endmodule

// File: tb/tb_oup_ulpi_phy_model.sv
// Directed bench for oup_ulpi_phy_model: a table of register transactions
// plus hand-written sequences for RX CMD timing, soft reset, aborts and
// async reset. Honours OUP_ULPI_PHY_NXT_THROTTLE_EN for nxt timing.
module tb_oup_ulpi_phy_model;

`ifdef OUP_ULPI_PHY_NXT_THROTTLE_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ls = 2'b00;
  logic [1:0] vbus = 2'b00;
  logic       id = 1'b0;
  logic [7:0] func_ctrl;
  logic       phy_reset;

  int checks = 0;
  int errors = 0;

  oup_ulpi_phy_model_if ulpi_if ();

  oup_ulpi_phy_model #(
    .VENDOR_ID  (16'h0424),
    .PRODUCT_ID (16'h0009),
    .NXT_DELAY  (2)
  ) dut (
    .ulpi_clk_i  (clk),
    .rst_n_i     (rst_n),
    .ulpi        (ulpi_if),
    .linestate_i (ls),
    .vbus_i      (vbus),
    .id_i        (id),
    .func_ctrl_o (func_ctrl),
    .phy_reset_o (phy_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_rd;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp_func;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Accept the TX CMD already on the bus and verify nxt timing.
  task automatic wait_cmd_ack(input string tag);
    tick();
    for (int i = 0; i < DLY; i++) begin
      chk1({tag, "_nxt_wait"}, ulpi_if.ulpi_nxt_o, 1'b0);
      tick();
    end
    chk1({tag, "_cmd_nxt"}, ulpi_if.ulpi_nxt_o, 1'b1);
    chk1({tag, "_cmd_dir"}, ulpi_if.ulpi_dir_o, 1'b0);
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [7:0] data);
    ulpi_if.ulpi_data_i = {2'b10, addr};
    ulpi_if.ulpi_stp_i  = 1'b0;
    wait_cmd_ack("wr");
    ulpi_if.ulpi_data_i = data;
    tick();
    chk1("wr_data_nxt", ulpi_if.ulpi_nxt_o, 1'b1);
    tick();
    chk1("wr_stp_nxt", ulpi_if.ulpi_nxt_o, 1'b0);
    ulpi_if.ulpi_data_i = 8'h00;
    ulpi_if.ulpi_stp_i  = 1'b1;
    tick();
    ulpi_if.ulpi_stp_i  = 1'b0;
    $display("WR addr %02h data %02h", addr, data);
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [7:0] exp);
    logic [7:0] got;
    ulpi_if.ulpi_data_i = {2'b11, addr};
    ulpi_if.ulpi_stp_i  = 1'b0;
    wait_cmd_ack("rd");
    ulpi_if.ulpi_data_i = 8'h00;
    tick();
    chk1("rd_turn_dir", ulpi_if.ulpi_dir_o, 1'b1);
    chk1("rd_turn_nxt", ulpi_if.ulpi_nxt_o, 1'b0);
    chk1("rd_turn_oe", ulpi_if.ulpi_data_oe_o, 1'b0);
    tick();
    got = ulpi_if.ulpi_data_o;
    chk1("rd_oe", ulpi_if.ulpi_data_oe_o, 1'b1);
    chk8($sformatf("rd_data_%02h", addr), got, exp);
    tick();
    chk1("rd_back_dir", ulpi_if.ulpi_dir_o, 1'b0);
    chk1("rd_back_oe", ulpi_if.ulpi_data_oe_o, 1'b0);
    tick();
    $display("RD addr %02h data %02h", addr, got);
  endtask

  // Starting in IDLE with an RX CMD due at the next edge.
  task automatic expect_rxcmd(input logic [7:0] exp);
    logic [7:0] got;
    tick();
    chk1("rx_turn_dir", ulpi_if.ulpi_dir_o, 1'b1);
    chk1("rx_turn_oe", ulpi_if.ulpi_data_oe_o, 1'b0);
    tick();
    got = ulpi_if.ulpi_data_o;
    chk1("rx_oe", ulpi_if.ulpi_data_oe_o, 1'b1);
    chk1("rx_nxt", ulpi_if.ulpi_nxt_o, 1'b0);
    chk8("rx_byte", got, exp);
    tick();
    chk1("rx_back_dir", ulpi_if.ulpi_dir_o, 1'b0);
    chk1("rx_back_oe", ulpi_if.ulpi_data_oe_o, 1'b0);
    tick();
    $display("RXCMD data %02h", got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    logic seen;

    ulpi_if.ulpi_data_i = 8'h00;
    ulpi_if.ulpi_stp_i  = 1'b0;

    // Register transactions: reads carry the expected value in data.
    vq.push_back(vec_t'{1'b1, 6'h04, 8'h41, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h00, 8'h24, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h01, 8'h04, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h02, 8'h09, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h03, 8'h00, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h0A, 8'h06, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h07, 8'h00, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h16, 8'h00, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h16, 8'hA5, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h16, 8'hA5, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h17, 8'h0A, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h18, 8'hAF, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h18, 8'h0F, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h16, 8'hA0, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h0B, 8'h01, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h0C, 8'h07, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h07, 8'h3C, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h09, 8'h3C, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h2F, 8'h55, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h2F, 8'h00, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h3F, 8'h00, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h04, 8'h45, 8'h45});
    vq.push_back(vec_t'{1'b1, 6'h05, 8'h45, 8'h45});
    vq.push_back(vec_t'{1'b0, 6'h06, 8'h04, 8'h41});
    vq.push_back(vec_t'{1'b1, 6'h04, 8'h41, 8'h41});
    vq.push_back(vec_t'{1'b0, 6'h05, 8'h02, 8'h43});
    vq.push_back(vec_t'{1'b1, 6'h06, 8'h43, 8'h43});

    // Reset state.
    repeat (3) tick();
    chk1("rst_dir", ulpi_if.ulpi_dir_o, 1'b0);
    chk1("rst_oe", ulpi_if.ulpi_data_oe_o, 1'b0);
    chk1("rst_nxt", ulpi_if.ulpi_nxt_o, 1'b0);
    chk8("rst_data_o", ulpi_if.ulpi_data_o, 8'h00);
    chk1("rst_phy_reset", phy_reset, 1'b0);
    chk8("rst_func_ctrl", func_ctrl, 8'h41);
    rst_n = 1'b1;

    // First RX CMD after reset, bounded to 4 cycles.
    seen = 1'b0;
    n = 0;
    while (!seen && n < 4) begin
      tick();
      n++;
      seen = ulpi_if.ulpi_dir_o;
    end
    chk1("boot_rx_dir", seen, 1'b1);
    chk1("boot_rx_turn_oe", ulpi_if.ulpi_data_oe_o, 1'b0);
    tick();
    chk1("boot_rx_oe", ulpi_if.ulpi_data_oe_o, 1'b1);
    chk8("boot_rx_byte", ulpi_if.ulpi_data_o, 8'h00);
    tick();
    chk1("boot_rx_back_dir", ulpi_if.ulpi_dir_o, 1'b0);
    tick();
    $display("RXCMD boot after %0d cycles", n);

    // Table-driven register traffic.
    foreach (vq[i]) begin
      if (vq[i].is_rd) do_read(vq[i].addr, vq[i].data);
      else do_write(vq[i].addr, vq[i].data);
      chk8($sformatf("vec%0d_func_ctrl", i), func_ctrl, vq[i].exp_func);
    end

    // Line state change during a read: RX CMD only after TURN_BACK + one IDLE.
    ulpi_if.ulpi_data_i = 8'hC4;
    wait_cmd_ack("lsrd");
    ulpi_if.ulpi_data_i = 8'h00;
    tick();
    chk1("lsrd_turn_dir", ulpi_if.ulpi_dir_o, 1'b1);
    ls = 2'b01;
    tick();
    chk8("lsrd_data", ulpi_if.ulpi_data_o, 8'h43);
    tick();
    chk1("lsrd_back_dir", ulpi_if.ulpi_dir_o, 1'b0);
    tick();
    chk1("lsrd_idle_dir", ulpi_if.ulpi_dir_o, 1'b0);
    $display("RD addr 04 with linestate change");
    expect_rxcmd(8'h01);

    // TX CMD wins over a pending RX CMD; the RX CMD follows the read.
    ls = 2'b10;
    vbus = 2'b11;
    id = 1'b1;
    do_write(6'h16, 8'h5A);
    do_read(6'h16, 8'h5A);
    expect_rxcmd(8'h4E);

    // Function Control Reset: defaults restored, pulse, RX CMD re-sent.
    do_write(6'h04, 8'h60);
    chk1("softrst_pulse", phy_reset, 1'b1);
    chk8("softrst_func", func_ctrl, 8'h41);
    expect_rxcmd(8'h4E);
    chk1("softrst_pulse_end", phy_reset, 1'b0);
    do_read(6'h16, 8'h00);
    do_read(6'h0A, 8'h06);
    do_read(6'h07, 8'h00);

    // stp in CMD_ACK aborts the write.
    do_write(6'h16, 8'h33);
    ulpi_if.ulpi_data_i = 8'h96;
    wait_cmd_ack("abort");
    ulpi_if.ulpi_data_i = 8'h77;
    ulpi_if.ulpi_stp_i  = 1'b1;
    tick();
    chk1("abort_nxt", ulpi_if.ulpi_nxt_o, 1'b0);
    ulpi_if.ulpi_data_i = 8'h00;
    ulpi_if.ulpi_stp_i  = 1'b0;
    tick();
    $display("WR addr 16 aborted in CMD_ACK");
    do_read(6'h16, 8'h33);

    // Missing stp after the data byte: write is discarded.
    ulpi_if.ulpi_data_i = 8'h96;
    wait_cmd_ack("nostp");
    ulpi_if.ulpi_data_i = 8'h99;
    tick();
    tick();
    chk1("nostp_nxt", ulpi_if.ulpi_nxt_o, 1'b0);
    ulpi_if.ulpi_data_i = 8'h00;
    tick();
    $display("WR addr 16 without stp");
    do_read(6'h16, 8'h33);

    // Unsupported command: nxt stays low until the link stops.
    ulpi_if.ulpi_data_i = 8'h41;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("unk_nxt", ulpi_if.ulpi_nxt_o, 1'b0);
      chk1("unk_dir", ulpi_if.ulpi_dir_o, 1'b0);
    end
    ulpi_if.ulpi_data_i = 8'h00;
    ulpi_if.ulpi_stp_i  = 1'b1;
    tick();
    ulpi_if.ulpi_stp_i  = 1'b0;
    $display("CMD 41 ignored");

    // Async reset while the PHY owns the bus.
    ulpi_if.ulpi_data_i = 8'hC4;
    wait_cmd_ack("arst");
    ulpi_if.ulpi_data_i = 8'h00;
    tick();
    chk1("arst_pre_dir", ulpi_if.ulpi_dir_o, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk1("arst_dir", ulpi_if.ulpi_dir_o, 1'b0);
    chk1("arst_oe", ulpi_if.ulpi_data_oe_o, 1'b0);
    tick();
    rst_n = 1'b1;
    $display("ASYNC reset during read");
    expect_rxcmd(8'h4E);
    chk8("arst_func", func_ctrl, 8'h41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
